// File: rtl/gcd_pkg.sv
// gcd_pkg: definitions shared by the GCD datapath and its control FSM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default widths, select encodings for xsel/ysel, status flag bundle.
package gcd_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;

  // Operand source selects as driven on xsel/ysel.
  localparam logic SEL_INPUT = 1'b1;  // take xin/yin
  localparam logic SEL_DIFF  = 1'b0;  // take the running difference

  // Status the control FSM branches on.
  typedef struct packed {
    logic eqflg;  // X == Y
    logic ltflg;  // X < Y, unsigned
    logic zflg;   // X == 0 or Y == 0
  } flags_t;

endpackage

// File: rtl/gcd_datapath_if.sv
// gcd_datapath_if: command/status bundle between the GCD control FSM and datapath.
// Latency: n/a (wires only).
// Backpressure: none; commands are acted on at every clock edge.
// master: FSM side, drives operands and load/select commands, reads flags/results.
// slave:  datapath side, the mirror image.
interface gcd_datapath_if
  import gcd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic [WIDTH-1:0] xin;
  logic [WIDTH-1:0] yin;
  logic             xsel;
  logic             ysel;
  logic             xld;
  logic             yld;
  logic             gld;
  logic             eqflg;
  logic             ltflg;
  logic             zflg;
  logic [WIDTH-1:0] gcd;
  logic             valid;
  logic [CNT_W-1:0] iters;

  modport master (
    output xin, yin, xsel, ysel, xld, yld, gld,
    input  eqflg, ltflg, zflg, gcd, valid, iters
  );

  modport slave (
    input  xin, yin, xsel, ysel, xld, yld, gld,
    output eqflg, ltflg, zflg, gcd, valid, iters
  );

endinterface

// File: rtl/gcd_sub_cmp.sv
// gcd_sub_cmp: both-direction differences and compare flags for the X/Y operands.
// Latency: purely combinational.
// Backpressure: none.
// Ports: x, y in; xmy = x-y, ymx = y-x (modulo 2^WIDTH); flags = {eq, lt, zero}.
module gcd_sub_cmp
  import gcd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] xmy,
  output logic [WIDTH-1:0] ymx,
  output flags_t           flags
);

  // Both differences are always produced so a simultaneous X and Y subtract
  // load sees values computed from the same pre-edge operands.
  assign xmy = x - y;
  assign ymx = y - x;

  always_comb begin
    flags       = '0;
    flags.eqflg = (x == y);
    flags.ltflg = (x < y);
    flags.zflg  = (x == '0) || (y == '0);
  end

endmodule

// File: rtl/gcd_datapath.sv
// gcd_datapath: X/Y operand registers, G result, iteration counter and valid flag for the GCD FSM.
// Latency: loads take effect on the clock edge; flags follow X/Y with no extra pipeline stage.
// Backpressure: none; every asserted load is executed on the next edge.
// Ports: clk, clr (async, active-high), dp (slave side of gcd_datapath_if).
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic           clk,
  input logic           clr,
  gcd_datapath_if.slave dp
);

  localparam logic [CNT_W-1:0] ITERS_MAX = '1;

  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] g_q;
  logic             valid_q;
  logic [CNT_W-1:0] iters_q;

  logic [WIDTH-1:0] xmy;
  logic [WIDTH-1:0] ymx;
  flags_t           flags;

  logic [WIDTH-1:0] x_src;
  logic [WIDTH-1:0] y_src;
  logic             op_ld;
  logic             sub_ld;

  gcd_sub_cmp #(
    .WIDTH (WIDTH)
  ) u_sub_cmp (
    .x     (x_q),
    .y     (y_q),
    .xmy   (xmy),
    .ymx   (ymx),
    .flags (flags)
  );

  assign x_src = (dp.xsel == SEL_INPUT) ? dp.xin : xmy;
  assign y_src = (dp.ysel == SEL_INPUT) ? dp.yin : ymx;

  // A fresh operand starts a new computation; a subtract load is one
  // iteration of the current one. Both X and Y subtracting counts once.
  assign op_ld  = (dp.xld && (dp.xsel == SEL_INPUT)) || (dp.yld && (dp.ysel == SEL_INPUT));
  assign sub_ld = (dp.xld && (dp.xsel == SEL_DIFF))  || (dp.yld && (dp.ysel == SEL_DIFF));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      x_q     <= '0;
      y_q     <= '0;
      g_q     <= '0;
      valid_q <= 1'b0;
      iters_q <= '0;
    end else begin
      if (dp.xld) x_q <= x_src;
      if (dp.yld) y_q <= y_src;
      // G always takes the pre-edge X, even when X is reloaded this cycle.
      if (dp.gld) g_q <= x_q;

      // A new operand invalidates the result, even if G is latched this cycle.
      if (op_ld)       valid_q <= 1'b0;
      else if (dp.gld) valid_q <= 1'b1;

      if (op_ld)
        iters_q <= '0;
      else if (sub_ld && (iters_q != ITERS_MAX))
        iters_q <= iters_q + CNT_W'(1);
    end
  end

  assign dp.eqflg = flags.eqflg;
  assign dp.ltflg = flags.ltflg;
  assign dp.zflg  = flags.zflg;
  assign dp.gcd   = g_q;
  assign dp.valid = valid_q;
  assign dp.iters = iters_q;

endmodule
